// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S deserializer; frames words on lrck edges and
// presents each left/right pair on a valid/ready interface.
module i2s_rx #(
    parameter int WIDTH       = 24,
    parameter int DELAY       = 1,
    parameter int LEFT_LEVEL  = 0,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_SLOTS   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bck,
    input  logic             i_lrck,
    input  logic             i_sdata,
    input  logic             i_ready,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_overrun,
    output logic             o_short_word
);
    localparam int SW = $clog2(MAX_SLOTS + 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(MAX_SLOTS);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, sdata_sync_q;
    logic                   bck_prev_q, rise_q, lrck_prev_q;
    logic                   emit_q, emit_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic [WIDTH-1:0]       left_hold_q, left_hold_d, right_hold_q, right_hold_d;
    logic [WIDTH-1:0]       left_q, left_d, right_q, right_d;
    logic                   valid_q, valid_d, overrun_q, overrun_d, short_q, short_d;
    logic                   short_set;
    state_t                 state_q, state_d;
    logic                   bck_s, lrck_s, sdata_s, lrck_chg, short_close, accept;
    int                     slot_k;

    assign bck_s       = bck_sync_q[SYNC_STAGES-1];
    assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s     = sdata_sync_q[SYNC_STAGES-1];
    assign lrck_chg    = lrck_s != lrck_prev_q;
    // slot_q is the last slot index of the word being closed
    assign short_close = int'(slot_q) < DELAY + WIDTH - 1;
    assign accept      = !valid_q || i_ready;

    assign o_left       = left_q;
    assign o_right      = right_q;
    assign o_valid      = valid_q;
    assign o_locked     = state_q != HUNT;
    assign o_overrun    = overrun_q;
    assign o_short_word = short_q;

    always_comb begin
        slot_d = slot_q;
        word_d = word_q;
        slot_k = 0;
        if (rise_q) begin
            slot_d = lrck_chg ? '0 : (slot_q == SLOT_MAX ? slot_q : slot_q + SW'(1));
            slot_k = int'(slot_d);
            word_d = lrck_chg ? '0 : word_q;
            if (slot_k >= DELAY && slot_k < DELAY + WIDTH)
                word_d = word_d | (WIDTH'(sdata_s) << (WIDTH - 1 - slot_k + DELAY));
        end
    end

    always_comb begin
        state_d      = state_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        emit_d       = 1'b0;
        short_set    = 1'b0;
        if (rise_q) begin
            if (lrck_chg) begin
                case (state_q)
                    HUNT: if (lrck_s == 1'(LEFT_LEVEL)) state_d = LEFT;
                    LEFT: begin
                        left_hold_d = word_q;
                        short_set   = short_close;
                        state_d     = RIGHT;
                    end
                    RIGHT: begin
                        right_hold_d = word_q;
                        short_set    = short_close;
                        emit_d       = 1'b1;
                        state_d      = LEFT;
                    end
                    default: state_d = HUNT;
                endcase
            end else if (slot_d == SLOT_MAX) begin
                state_d = HUNT;
            end
        end
    end

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q && !i_ready;
        if (emit_q && accept) begin
            left_d  = left_hold_q;
            right_d = right_hold_q;
            valid_d = 1'b1;
        end
        overrun_d = (emit_q && !accept) || (overrun_q && !i_clr_err);
        short_d   = short_set || (short_q && !i_clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= HUNT;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bck_sync_q   <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            bck_prev_q   <= 1'b0;
            rise_q       <= 1'b0;
            lrck_prev_q  <= 1'b0;
            slot_q       <= '0;
            word_q       <= '0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            emit_q       <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            bck_sync_q   <= {bck_sync_q[SYNC_STAGES-2:0], i_bck};
            lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], i_lrck};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i_sdata};
            bck_prev_q   <= bck_s;
            rise_q       <= bck_s && !bck_prev_q;
            if (rise_q) lrck_prev_q <= lrck_s;
            slot_q       <= slot_d;
            word_q       <= word_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            emit_q       <= emit_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            short_q      <= short_d;
        end
    end
endmodule
